// File: rtl/sap_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sap_control_sequencer
//  Purpose  : Six-state T-cycle ring and opcode decoder for the 8-bit
//             accumulator CPU. It produces the per-cycle control word for
//             the PC, MAR, RAM, IR, accumulator, B register, ALU and output
//             register, and counts completed instruction fetches.
//  Revision : 1.0 - initial release
// ============================================================================
module sap_control_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  output logic             pc_out,
  output logic             mar_in,
  output logic             pc_inc,
  output logic             ram_out,
  output logic             ir_in,
  output logic             ir_out,
  output logic             acc_in,
  output logic             acc_out,
  output logic             b_in,
  output logic             alu_sub,
  output logic             alu_out,
  output logic             out_in,
  output logic [2:0]       t_state,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  // The state encoding doubles as the externally visible t_state value.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [3:0] C_OP_LDA = 4'b0000;
  localparam logic [3:0] C_OP_ADD = 4'b0001;
  localparam logic [3:0] C_OP_SUB = 4'b0010;
  localparam logic [3:0] C_OP_OUT = 4'b1110;
  localparam logic [3:0] C_OP_HLT = 4'b1111;

  state_t r_state;
  state_t w_next_state;
  logic [CNT_W-1:0] r_fetch_count;

  // State register; reset returns to IDLE from anywhere, including HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fetch counter advances as the IR captures, i.e. on leaving T3; it wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (r_state == S_T3) begin
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  // Next-state logic; HLT is resolved in T4 once the opcode is valid.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: w_next_state = start ? S_T1 : S_IDLE;
      S_T1:   w_next_state = S_T2;
      S_T2:   w_next_state = S_T3;
      S_T3:   w_next_state = S_T4;
      S_T4:   w_next_state = (opcode == C_OP_HLT) ? S_HALT : S_T5;
      S_T5:   w_next_state = S_T6;
      S_T6:   w_next_state = S_T1;
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control word decode: fetch cycles depend on state only, execute cycles
  // also on the opcode; unlisted opcodes fall through as all-zero NOPs.
  always_comb begin
    pc_out  = 1'b0;
    mar_in  = 1'b0;
    pc_inc  = 1'b0;
    ram_out = 1'b0;
    ir_in   = 1'b0;
    ir_out  = 1'b0;
    acc_in  = 1'b0;
    acc_out = 1'b0;
    b_in    = 1'b0;
    alu_sub = 1'b0;
    alu_out = 1'b0;
    out_in  = 1'b0;
    unique case (r_state)
      S_T1: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
      end
      S_T2: pc_inc = 1'b1;
      S_T3: begin
        ram_out = 1'b1;
        ir_in   = 1'b1;
        ir_out  = 1'b1;
      end
      S_T4: begin
        if (opcode == C_OP_LDA || opcode == C_OP_ADD || opcode == C_OP_SUB) begin
          ir_out = 1'b1;
          mar_in = 1'b1;
        end else if (opcode == C_OP_OUT) begin
          acc_out = 1'b1;
          out_in  = 1'b1;
        end
      end
      S_T5: begin
        if (opcode == C_OP_LDA) begin
          ram_out = 1'b1;
          acc_in  = 1'b1;
        end else if (opcode == C_OP_ADD || opcode == C_OP_SUB) begin
          ram_out = 1'b1;
          b_in    = 1'b1;
        end
      end
      S_T6: begin
        if (opcode == C_OP_ADD || opcode == C_OP_SUB) begin
          alu_out = 1'b1;
          acc_in  = 1'b1;
          alu_sub = (opcode == C_OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign t_state     = r_state;
  assign halted      = (r_state == S_HALT);
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_sap_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sap_control_sequencer
//  Purpose  : Self-checking bench for sap_control_sequencer: directed
//             scenarios plus randomized traffic against an instruction-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sap_control_sequencer;

  localparam int CNT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  // Control word bit positions, packed as
  // {pc_out,mar_in,pc_inc,ram_out,ir_in,ir_out,acc_in,acc_out,b_in,alu_sub,alu_out,out_in}
  localparam logic [11:0] PC_OUT  = 12'h800;
  localparam logic [11:0] MAR_IN  = 12'h400;
  localparam logic [11:0] PC_INC  = 12'h200;
  localparam logic [11:0] RAM_OUT = 12'h100;
  localparam logic [11:0] IR_IN   = 12'h080;
  localparam logic [11:0] IR_OUT  = 12'h040;
  localparam logic [11:0] ACC_IN  = 12'h020;
  localparam logic [11:0] ACC_OUT = 12'h010;
  localparam logic [11:0] B_IN    = 12'h008;
  localparam logic [11:0] ALU_SUB = 12'h004;
  localparam logic [11:0] ALU_OUT = 12'h002;
  localparam logic [11:0] OUT_IN  = 12'h001;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [3:0] opcode;
  logic pc_out, mar_in, pc_inc, ram_out, ir_in, ir_out;
  logic acc_in, acc_out, b_in, alu_sub, alu_out, out_in;
  logic [2:0] t_state;
  logic halted;
  logic [CNT_W-1:0] fetch_count;

  sap_control_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .pc_out(pc_out), .mar_in(mar_in), .pc_inc(pc_inc), .ram_out(ram_out),
    .ir_in(ir_in), .ir_out(ir_out), .acc_in(acc_in), .acc_out(acc_out),
    .b_in(b_in), .alu_sub(alu_sub), .alu_out(alu_out), .out_in(out_in),
    .t_state(t_state), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  wire [11:0] dut_ctrl = {pc_out, mar_in, pc_inc, ram_out, ir_in, ir_out,
                          acc_in, acc_out, b_in, alu_sub, alu_out, out_in};

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = running an instruction, 2 = halted.
  // phase is the 1-based cycle index within the current six-cycle instruction.
  int m_mode  = 0;
  int m_phase = 0;
  int m_cnt   = 0;

  // Values sampled in the most recent step, for directed literal checks.
  logic [11:0] s_ctrl;
  logic [2:0]  s_t;
  logic        s_halt;
  logic [CNT_W-1:0] s_cnt;

  function automatic logic [11:0] exp_ctrl(input int mode, input int ph, input logic [3:0] op);
    logic [11:0] w;
    w = '0;
    if (mode == 1) begin
      case (ph)
        1: w = PC_OUT | MAR_IN;
        2: w = PC_INC;
        3: w = RAM_OUT | IR_IN | IR_OUT;
        4: if (op == 4'd0 || op == 4'd1 || op == 4'd2) w = IR_OUT | MAR_IN;
           else if (op == 4'd14) w = ACC_OUT | OUT_IN;
        5: if (op == 4'd0) w = RAM_OUT | ACC_IN;
           else if (op == 4'd1 || op == 4'd2) w = RAM_OUT | B_IN;
        6: if (op == 4'd1) w = ALU_OUT | ACC_IN;
           else if (op == 4'd2) w = ALU_OUT | ACC_IN | ALU_SUB;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  function automatic logic [2:0] exp_t(input int mode, input int ph);
    if (mode == 2) return 3'd7;
    if (mode == 1) return 3'(ph);
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance
  // the model across the rising edge with the same inputs the DUT saw.
  task automatic step(input logic s, input logic r, input logic [3:0] op);
    @(negedge clk);
    start  = s;
    rst    = r;
    opcode = op;
    #1;
    s_ctrl = dut_ctrl;
    s_t    = t_state;
    s_halt = halted;
    s_cnt  = fetch_count;
    check("ctrl",        {4'd0, dut_ctrl},       {4'd0, exp_ctrl(m_mode, m_phase, op)});
    check("t_state",     {13'd0, t_state},       {13'd0, exp_t(m_mode, m_phase)});
    check("halted",      {15'd0, halted},        {15'd0, (m_mode == 2)});
    check("fetch_count", {8'd0, fetch_count},    16'(m_cnt));
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_phase = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_phase = 1; end
    end else if (m_mode == 1) begin
      if (m_phase == 3) m_cnt = (m_cnt + 1) % CNT_MOD;
      if (m_phase == 4 && op == 4'd15) m_mode = 2;
      else m_phase = (m_phase % 6) + 1;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 4'd0);
  endtask

  logic [3:0] pool [6] = '{4'd0, 4'd1, 4'd2, 4'd14, 4'd3, 4'd11};
  logic [3:0] cur_op;

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 4'd0;
    // Reset and idle
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'($urandom_range(15)));
    check("idle_t", {13'd0, s_t}, 16'd0);
    check("idle_cnt", {8'd0, s_cnt}, 16'd0);

    // LDA then ADD
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check("lda_t1", {4'd0, s_ctrl}, 16'hC00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'd1);
    check("add_t6", {4'd0, s_ctrl}, 16'h022);
    step(1'b0, 1'b0, 4'd2);
    check("cnt_after_2", {8'd0, s_cnt}, 16'd2);
    check("t1_no_bubble", {13'd0, s_t}, 16'd1);

    // SUB then OUT
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd2);
    check("sub_t6", {4'd0, s_ctrl}, 16'h026);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd14);
    check("out_t4", {4'd0, s_ctrl}, 16'h011);
    step(1'b0, 1'b0, 4'd14);
    check("out_t5", {4'd0, s_ctrl}, 16'h000);
    step(1'b0, 1'b0, 4'd14);

    // HLT at first fetch
    do_reset();
    step(1'b1, 1'b0, 4'd15);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd15);
    check("hlt_t4", {13'd0, s_t}, 16'd4);
    step(1'b0, 1'b0, 4'd15);
    check("hlt_halted", {15'd0, s_halt}, 16'd1);
    for (int i = 0; i < 10; i++) step(1'(i & 1), 1'b0, 4'($urandom_range(15)));
    check("hlt_hold_t", {13'd0, s_t}, 16'd7);
    check("hlt_cnt", {8'd0, s_cnt}, 16'd1);
    do_reset();
    step(1'b0, 1'b0, 4'd0);
    check("hlt_rst_t", {13'd0, s_t}, 16'd0);

    // Reset during T5 of ADD
    step(1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd1);
    step(1'b0, 1'b1, 4'd1);
    check("mid_t5_b_in", {4'd0, s_ctrl}, 16'h108);
    step(1'b0, 1'b0, 4'd1);
    check("mid_rst_t", {13'd0, s_t}, 16'd0);
    check("mid_rst_b_in", {4'd0, s_ctrl}, 16'h000);
    check("mid_rst_cnt", {8'd0, s_cnt}, 16'd0);
    step(1'b1, 1'b0, 4'd1);
    step(1'b0, 1'b0, 4'd1);
    check("restart_t1", {4'd0, s_ctrl}, 16'hC00);

    // Wrap with NOPs
    do_reset();
    step(1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 256 * 6; i++) step(1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 4'd5);
    check("wrap_cnt", {8'd0, s_cnt}, 16'd0);

    // Randomized traffic
    cur_op = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      logic r, s;
      logic [3:0] op;
      r = ($urandom_range(99) == 0) || (m_mode == 2 && $urandom_range(9) == 0);
      s = 1'($urandom_range(1));
      if (m_mode == 1 && m_phase == 3)
        cur_op = ($urandom_range(19) == 0) ? 4'd15 : pool[$urandom_range(5)];
      if (m_mode == 1 && m_phase >= 4) op = cur_op;
      else op = 4'($urandom_range(15));
      step(s, r, op);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Control sequencer for the 8-bit accumulator microprocessor. It steps a six-state T-cycle ring and decodes the 4-bit opcode held in the instruction register into the per-cycle control word. That control word drives the PC, MAR, RAM, IR, accumulator, B register, ALU and output register. The block sits beside the IR: it asserts `ir_in`/`ir_out` during fetch and consumes `data_out[7:4]` of the IR as `opcode` during execute.

## Interface
Parameters:
- `CNT_W`, default 8: width of the retired-fetch counter.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE and begin fetching; sampled only in IDLE.
- `opcode` in 4: IR high nibble; must be stable from T4 through T6.
- `pc_out`, `mar_in`, `pc_inc`, `ram_out`, `ir_in`, `ir_out`, `acc_in`, `acc_out`, `b_in`, `alu_sub`, `alu_out`, `out_in` out 1 each: control word, active-high.
- `t_state` out 3: 0 = IDLE, 1..6 = T1..T6, 7 = HALTED.
- `halted` out 1: high while in HALTED.
- `fetch_count` out CNT_W: count of completed fetches.

## Operation
- States: IDLE, T1, T2, T3, T4, T5, T6, HALTED; the register is encoded per `t_state`.
- Transitions:
  - IDLE→T1 when `start`=1; otherwise stay in IDLE.
  - T1→T2→T3→T4 unconditionally.
  - T4→HALTED if `opcode`=4'b1111; otherwise T4→T5.
  - T5→T6, then T6→T1.
  - HALTED persists until `rst`.
- Control word is a Moore decode of current state plus `opcode` (T4–T6 only); every signal not listed below is 0:
  - T1: `pc_out`, `mar_in`.
  - T2: `pc_inc`.
  - T3: `ram_out`, `ir_in`, `ir_out`.
  - LDA 0000: T4 `ir_out`+`mar_in`; T5 `ram_out`+`acc_in`; T6 none.
  - ADD 0001: T4 `ir_out`+`mar_in`; T5 `ram_out`+`b_in`; T6 `alu_out`+`acc_in`.
  - SUB 0010: as ADD, with `alu_sub` added in T6 only.
  - OUT 1110: T4 `acc_out`+`out_in`; T5 and T6 none.
  - HLT 1111: T4 none; the next state is HALTED.
  - Any other opcode: NOP, with all controls 0 in T4–T6; the sequence still runs through T6.
- IDLE and HALTED: all controls 0.
- `fetch_count`: +1 on each T3→T4 edge, including for HLT and NOP. Wraps from 2^CNT_W−1 to 0; no saturation.
- `start` outside IDLE is ignored. `opcode` outside T4–T6 is ignored.

## Timing
- Reset (`rst`=1 at an edge): next cycle state=IDLE, `t_state`=0, `halted`=0, `fetch_count`=0, all controls 0. Reset wins over every other condition, including mid-instruction and in HALTED.
- Start latency: `start` high at edge k puts the block in T1 for cycle k+1, with `pc_out`/`mar_in` high that cycle.
- Steady state: one instruction every 6 cycles. The T1 of the next instruction immediately follows T6, with no bubble.
- IR handshake: `ir_in` and `ir_out` are both high in T3. The IR captures at the T3→T4 edge, and `opcode` is valid from the start of T4.
- HLT: from `start` accepted at edge k, HALTED is entered at edge k+4, and `halted`=1 from that cycle on.
- Outputs change only after clock edges, as a decode of the registered state; the only combinational input dependency is `opcode` in T4–T6.

## Test plan
- Reset and idle: hold `rst` 2 cycles, then `start`=0 for 5 cycles → `t_state`=0, all controls 0, `fetch_count`=0 throughout.
- LDA then ADD: pulse `start`, opcode 0000 then 0001 → T1..T6 control words exactly as listed, 12 cycles total, `fetch_count`=2, T6 of ADD has `alu_out`=`acc_in`=1 and `alu_sub`=0.
- SUB and OUT: opcode 0010 then 1110 → `alu_sub`=1 only in SUB T6; OUT T4 has `acc_out`=`out_in`=1 and T5/T6 are all-zero.
- HLT: opcode 1111 at first fetch → `halted`=1 from cycle 5 after `start`. Hold 10 cycles with `start` toggling → remains in HALTED with controls 0. Then `rst` → IDLE.
- Reset mid-instruction: assert `rst` during T5 of ADD → next cycle IDLE, `b_in`=0, `fetch_count`=0. A new `start` re-fetches from T1.
- Wrap and NOP: CNT_W=8, opcode 0101, run 256 instructions → all controls 0 in T4–T6 for every instruction, and `fetch_count` returns to 0 after the 256th T3→T4 edge.
